// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: takes over the shared datapath lines to push the resume PC
// (and optionally the CCR flags) onto the stack, then pulses the vector load.
//
// Build option: define INTERRUPT_CTRL_SAVE_FLAGS_EN to include the PUSH_FLAGS
// step (4-cycle sequence). Without it the sequence is 3 cycles and the flags
// are not pushed.
//
// State       | Meaning
// ------------+----------------------------------------------------------
// IDLE        | no sequence; shared lines released (high-impedance)
// PUSH_PC_H   | push upper half of the saved PC
// PUSH_PC_L   | push lower half of the saved PC
// PUSH_FLAGS  | push {13'b0, C, N, Z} (only with flag saving built in)
// LOAD_VEC    | one-cycle branch to the interrupt vector, then back to IDLE

module interrupt_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int_req,
    input  logic        stall,
    input  logic [31:0] pc_in,
    input  logic [2:0]  flags_in,
    output logic        int_flag,
    output wire  [3:0]  alu_function,
    output wire         branch,
    output wire         data_read,
    output wire         data_write,
    output wire         DMW,
    output wire         stack_operation,
    output wire         push_pop,
    output wire         write_sp,
    output logic [15:0] push_data,
    output logic        vec_pc_load
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PUSH_PC_H  = 3'd1,
        PUSH_PC_L  = 3'd2,
        PUSH_FLAGS = 3'd3,
        LOAD_VEC   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic        int_req_q, int_req_d;
    logic [31:0] pc_save_q, pc_save_d;
    logic [2:0]  flags_save_q, flags_save_d;
    logic        int_req_rise;

    logic [3:0]  alu_function_drv;
    logic        branch_drv;
    logic        data_read_drv;
    logic        data_write_drv;
    logic        dmw_drv;
    logic        stack_operation_drv;
    logic        push_pop_drv;
    logic        write_sp_drv;

    // Edges keep being sampled during stalls so no request is lost.
    assign int_req_rise = int_req & ~int_req_q;
    assign int_req_d    = int_req;

    // State, pending bit, captured PC/flags and the int_req sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            int_req_q    <= 1'b0;
            pc_save_q    <= 32'h0;
            flags_save_q <= 3'b000;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            int_req_q    <= int_req_d;
            pc_save_q    <= pc_save_d;
            flags_save_q <= flags_save_d;
        end
    end

    // Next state; an edge arriving in the start cycle re-arms pending.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | int_req_rise;
        pc_save_d    = pc_save_q;
        flags_save_d = flags_save_q;
        case (state_q)
            IDLE: begin
                if (pending_q && !stall) begin
                    state_d      = PUSH_PC_H;
                    pc_save_d    = pc_in;
                    flags_save_d = flags_in;
                    pending_d    = int_req_rise;
                end
            end
            PUSH_PC_H: begin
                if (!stall) state_d = PUSH_PC_L;
            end
            PUSH_PC_L: begin
`ifdef INTERRUPT_CTRL_SAVE_FLAGS_EN
                if (!stall) state_d = PUSH_FLAGS;
`else
                if (!stall) state_d = LOAD_VEC;
`endif
            end
            PUSH_FLAGS: begin
                if (!stall) state_d = LOAD_VEC;
            end
            LOAD_VEC: begin
                if (!stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from the registered state only, so a stall holds them.
    always_comb begin
        int_flag            = 1'b0;
        push_data           = 16'h0000;
        vec_pc_load         = 1'b0;
        alu_function_drv    = 4'b0000;
        branch_drv          = 1'b0;
        data_read_drv       = 1'b0;
        data_write_drv      = 1'b0;
        dmw_drv             = 1'b0;
        stack_operation_drv = 1'b0;
        push_pop_drv        = 1'b0;
        write_sp_drv        = 1'b0;
        case (state_q)
            PUSH_PC_H, PUSH_PC_L, PUSH_FLAGS: begin
                int_flag            = 1'b1;
                alu_function_drv    = 4'b0100;
                dmw_drv             = 1'b1;
                stack_operation_drv = 1'b1;
                push_pop_drv        = 1'b1;
                write_sp_drv        = 1'b1;
                if (state_q == PUSH_PC_H)
                    push_data = pc_save_q[31:16];
                else if (state_q == PUSH_PC_L)
                    push_data = pc_save_q[15:0];
                else
                    push_data = {13'b0, flags_save_q};
            end
            LOAD_VEC: begin
                int_flag    = 1'b1;
                branch_drv  = 1'b1;
                vec_pc_load = 1'b1;
            end
            default: ;
        endcase
    end

    // Shared lines are released whenever no sequence owns them.
    assign alu_function    = int_flag ? alu_function_drv    : 4'bzzzz;
    assign branch          = int_flag ? branch_drv          : 1'bz;
    assign data_read       = int_flag ? data_read_drv       : 1'bz;
    assign data_write      = int_flag ? data_write_drv      : 1'bz;
    assign DMW             = int_flag ? dmw_drv             : 1'bz;
    assign stack_operation = int_flag ? stack_operation_drv : 1'bz;
    assign push_pop        = int_flag ? push_pop_drv        : 1'bz;
    assign write_sp        = int_flag ? write_sp_drv        : 1'bz;

endmodule
